turn_sequencer: RTL and testbench

Sequences the players' turns and track positions for the chicken-race game datapath. It is the consumer of the flip-result handshake from the top-level game controller. It holds the active player, each player's position on a circular track, and the skip-over-occupied-tile rule. It declares the winner when a player completes a lap, and drives the position and winner outputs used by the display logic.

---
 rtl/turn_seq_pkg.sv | 29 ++
 rtl/turn_sequencer_tile_occupancy.sv | 27 ++
 rtl/turn_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_turn_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_seq_pkg.sv
// Shared constants, FSM encoding and track arithmetic for the chicken-race turn sequencer.
package turn_seq_pkg;

  localparam int TRACK_LEN   = 24;
  localparam int MAX_PLAYERS = 4;
  localparam int POS_W       = 5;
  localparam int PID_W       = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_STEP  = 3'd3,
    S_CHECK = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Compare-and-wrap keeps the track circular for any TRACK_LEN, not just powers of two.
  function automatic logic [POS_W-1:0] wrap_inc(input logic [POS_W-1:0] pos,
                                                 input logic [POS_W-1:0] last_tile);
    if (pos == last_tile) begin
      return {POS_W{1'b0}};
    end else begin
      return pos + POS_W'(1);
    end
  endfunction

endpackage

// File: rtl/turn_sequencer_tile_occupancy.sv
// Flags a candidate tile held by another active player; the shared nest (tile 0) is never occupied.
module tile_occupancy
  import turn_seq_pkg::*;
#(
  parameter int MAX_PLAYERS_P = MAX_PLAYERS,
  parameter int POS_W_P       = POS_W
) (
  input  logic [POS_W_P-1:0]               i_cand,
  input  logic [MAX_PLAYERS_P*POS_W_P-1:0] i_pos_flat,
  input  logic [2:0]                       i_n,
  input  logic [PID_W-1:0]                 i_cur,
  output logic                             o_occupied
);

  // OR-reduce the per-player hits, masking the mover and inactive ids.
  always_comb begin
    o_occupied = 1'b0;
    for (int i = 0; i < MAX_PLAYERS_P; i++) begin
      o_occupied = o_occupied |
                   ((i_cand != {POS_W_P{1'b0}}) &&
                    (3'(i) < i_n) &&
                    (PID_W'(i) != i_cur) &&
                    (i_pos_flat[i*POS_W_P +: POS_W_P] == i_cand));
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer: consumes flip results, moves players round a circular track with
// skip-over-occupied tiles, and latches the winner on the first completed lap.
module turn_sequencer
  import turn_seq_pkg::*;
#(
  parameter int TRACK_LEN_P   = TRACK_LEN,
  parameter int MAX_PLAYERS_P = MAX_PLAYERS,
  parameter int POS_W_P       = POS_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [2:0]                       n_players,
  output logic                             cfg_err,
  input  logic                             res_valid,
  input  logic                             res_match,
  output logic                             res_ready,
  output logic [PID_W-1:0]                 cur_player,
  output logic [POS_W_P-1:0]               cur_pos,
  output logic [MAX_PLAYERS_P*POS_W_P-1:0] pos_flat,
  output logic                             win,
  output logic [PID_W-1:0]                 winner,
  output logic [2:0]                       state
);

  localparam logic [POS_W_P-1:0] LAST_TILE = POS_W_P'(TRACK_LEN_P - 1);

  state_t                         r_state;
  state_t                         w_next_state;
  logic [2:0]                     r_n;
  logic [PID_W-1:0]               r_cur;
  logic [POS_W_P-1:0]             r_pos [MAX_PLAYERS_P];
  logic [POS_W_P-1:0]             r_cand;
  logic                           r_wrap;
  logic                           r_win;
  logic [PID_W-1:0]               r_winner;
  logic                           r_res_ready;
  logic                           r_cfg_err;
  logic                           w_res_ready_d;
  logic                           w_cfg_err_d;
  logic                           w_n_ok;
  logic                           w_accept;
  logic                           w_occupied;
  logic [2:0]                     w_cur_plus;
  logic [POS_W_P-1:0]             w_cur_pos;
  logic [MAX_PLAYERS_P*POS_W_P-1:0] w_pos_flat;

  assign w_n_ok     = (n_players >= 3'd2) && (n_players <= 3'(MAX_PLAYERS_P));
  assign w_accept   = (r_state == S_WAIT) && res_valid;
  assign w_cur_plus = {1'b0, r_cur} + 3'd1;
  assign w_cur_pos  = r_pos[r_cur];

  // Flatten the position array for the occupancy compare and the display port.
  always_comb begin
    w_pos_flat = {(MAX_PLAYERS_P*POS_W_P){1'b0}};
    for (int i = 0; i < MAX_PLAYERS_P; i++) begin
      w_pos_flat[i*POS_W_P +: POS_W_P] = r_pos[i];
    end
  end

  tile_occupancy #(
    .MAX_PLAYERS_P (MAX_PLAYERS_P),
    .POS_W_P       (POS_W_P)
  ) u_occ (
    .i_cand     (r_cand),
    .i_pos_flat (w_pos_flat),
    .i_n        (r_n),
    .i_cur      (r_cur),
    .o_occupied (w_occupied)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = (start && w_n_ok) ? S_LOAD : S_IDLE;
      S_LOAD:  w_next_state = S_WAIT;
      S_WAIT: begin
        if (res_valid) begin
          w_next_state = res_match ? S_STEP : S_NEXT;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_STEP:  w_next_state = w_occupied ? S_STEP : S_CHECK;
      S_CHECK: w_next_state = r_wrap ? S_DONE : S_WAIT;
      S_NEXT:  w_next_state = S_WAIT;
      S_DONE:  w_next_state = (start && w_n_ok) ? S_LOAD : S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM output decode, computed one cycle early so the ports come straight from flops.
  always_comb begin
    w_res_ready_d = (w_next_state == S_WAIT);
    if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
      w_cfg_err_d = start && !w_n_ok;
    end else begin
      w_cfg_err_d = 1'b0;
    end
  end

  // Datapath: player count, turn owner, positions, candidate walk and winner latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n         <= 3'd2;
      r_cur       <= {PID_W{1'b0}};
      r_cand      <= {POS_W_P{1'b0}};
      r_wrap      <= 1'b0;
      r_win       <= 1'b0;
      r_winner    <= {PID_W{1'b0}};
      r_res_ready <= 1'b0;
      r_cfg_err   <= 1'b0;
      for (int i = 0; i < MAX_PLAYERS_P; i++) begin
        r_pos[i] <= {POS_W_P{1'b0}};
      end
    end else begin
      r_res_ready <= w_res_ready_d;
      r_cfg_err   <= w_cfg_err_d;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && w_n_ok) begin
            r_n   <= n_players;
            r_win <= 1'b0;
          end
        end
        S_LOAD: begin
          r_cur  <= {PID_W{1'b0}};
          r_wrap <= 1'b0;
          r_win  <= 1'b0;
          for (int i = 0; i < MAX_PLAYERS_P; i++) begin
            r_pos[i] <= {POS_W_P{1'b0}};
          end
        end
        S_WAIT: begin
          if (w_accept && res_match) begin
            r_cand <= wrap_inc(w_cur_pos, LAST_TILE);
            r_wrap <= (w_cur_pos == LAST_TILE);
          end
        end
        S_STEP: begin
          // A skip can itself cross the nest, so the wrap flag is sticky here.
          if (w_occupied) begin
            r_cand <= wrap_inc(r_cand, LAST_TILE);
            if (r_cand == LAST_TILE) begin
              r_wrap <= 1'b1;
            end
          end else begin
            r_pos[r_cur] <= r_cand;
          end
        end
        S_CHECK: begin
          if (r_wrap) begin
            r_win    <= 1'b1;
            r_winner <= r_cur;
          end else begin
            r_wrap <= 1'b0;
          end
        end
        S_NEXT: begin
          r_cur <= (w_cur_plus >= r_n) ? {PID_W{1'b0}} : w_cur_plus[PID_W-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign cfg_err    = r_cfg_err;
  assign res_ready  = r_res_ready;
  assign cur_player = r_cur;
  assign cur_pos    = w_cur_pos;
  assign pos_flat   = w_pos_flat;
  assign win        = r_win;
  assign winner     = r_winner;
  assign state      = r_state;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: config errors, a table of turn results, skips,
// async reset mid-walk, and a full lap to a win.
module tb_turn_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  n_players;
  logic        cfg_err;
  logic        res_valid;
  logic        res_match;
  logic        res_ready;
  logic [1:0]  cur_player;
  logic [4:0]  cur_pos;
  logic [19:0] pos_flat;
  logic        win;
  logic [1:0]  winner;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  turn_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_players  (n_players),
    .cfg_err    (cfg_err),
    .res_valid  (res_valid),
    .res_match  (res_match),
    .res_ready  (res_ready),
    .cur_player (cur_player),
    .cur_pos    (cur_pos),
    .pos_flat   (pos_flat),
    .win        (win),
    .winner     (winner),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        match;
    int          gap;
    int          cur;
    logic [19:0] pos;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] pk(input int p0, input int p1, input int p2, input int p3);
    return {5'(p3), 5'(p2), 5'(p1), 5'(p0)};
  endfunction

  function automatic vec_t mk(input logic m, input int g, input int c, input logic [19:0] p);
    vec_t v;
    v.match = m;
    v.gap   = g;
    v.cur   = c;
    v.pos   = p;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [2:0] n);
    start     = 1'b1;
    n_players = n;
    @(negedge clk);
    start     = 1'b0;
    n_players = 3'd0;
  endtask

  // Offer one result, then count cycles from acceptance until res_ready returns.
  task automatic send_result(input logic m, output int gap);
    int w;
    w = 0;
    while (!res_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!res_ready) begin
      check("ready_timeout", {31'd0, res_ready}, 32'd1);
    end
    res_valid = 1'b1;
    res_match = m;
    @(negedge clk);
    res_valid = 1'b0;
    res_match = 1'b0;
    gap = 1;
    while (!res_ready && gap < 50) begin
      @(negedge clk);
      gap++;
    end
  endtask

  initial begin
    int gap;

    rst       = 1'b1;
    start     = 1'b0;
    n_players = 3'd0;
    res_valid = 1'b0;
    res_match = 1'b0;

    // n=3 game: rotation, advances, and skips over one and two occupied tiles.
    vecs.push_back(mk(1'b0, 2, 1, pk(0, 0, 0, 0)));
    vecs.push_back(mk(1'b0, 2, 2, pk(0, 0, 0, 0)));
    vecs.push_back(mk(1'b0, 2, 0, pk(0, 0, 0, 0)));
    vecs.push_back(mk(1'b0, 2, 1, pk(0, 0, 0, 0)));
    vecs.push_back(mk(1'b1, 3, 1, pk(0, 1, 0, 0)));
    vecs.push_back(mk(1'b1, 3, 1, pk(0, 2, 0, 0)));
    vecs.push_back(mk(1'b1, 3, 1, pk(0, 3, 0, 0)));
    vecs.push_back(mk(1'b1, 3, 1, pk(0, 4, 0, 0)));
    vecs.push_back(mk(1'b0, 2, 2, pk(0, 4, 0, 0)));
    vecs.push_back(mk(1'b1, 3, 2, pk(0, 4, 1, 0)));
    vecs.push_back(mk(1'b1, 3, 2, pk(0, 4, 2, 0)));
    vecs.push_back(mk(1'b1, 3, 2, pk(0, 4, 3, 0)));
    vecs.push_back(mk(1'b1, 4, 2, pk(0, 4, 5, 0)));
    vecs.push_back(mk(1'b0, 2, 0, pk(0, 4, 5, 0)));
    vecs.push_back(mk(1'b1, 3, 0, pk(1, 4, 5, 0)));
    vecs.push_back(mk(1'b1, 3, 0, pk(2, 4, 5, 0)));
    vecs.push_back(mk(1'b1, 3, 0, pk(3, 4, 5, 0)));
    vecs.push_back(mk(1'b1, 5, 0, pk(6, 4, 5, 0)));
    vecs.push_back(mk(1'b0, 2, 1, pk(6, 4, 5, 0)));
    vecs.push_back(mk(1'b1, 5, 1, pk(6, 7, 5, 0)));
    vecs.push_back(mk(1'b0, 2, 2, pk(6, 7, 5, 0)));

    @(negedge clk);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_ready", {31'd0, res_ready}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_win", {31'd0, win}, 32'd0);
    check("rst_pos_flat", {12'd0, pos_flat}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_start(3'd1);
    check("cfg_n1_err", {31'd0, cfg_err}, 32'd1);
    check("cfg_n1_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    check("cfg_err_one_cycle", {31'd0, cfg_err}, 32'd0);
    do_start(3'd5);
    check("cfg_n5_err", {31'd0, cfg_err}, 32'd1);
    check("cfg_n5_state", {29'd0, state}, 32'd0);
    do_start(3'd3);
    check("cfg_n3_err", {31'd0, cfg_err}, 32'd0);
    check("load_state", {29'd0, state}, 32'd1);
    check("load_ready", {31'd0, res_ready}, 32'd0);
    @(negedge clk);
    check("wait_state", {29'd0, state}, 32'd2);
    check("wait_ready", {31'd0, res_ready}, 32'd1);
    check("wait_cur", {30'd0, cur_player}, 32'd0);
    check("wait_pos", {12'd0, pos_flat}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      send_result(vecs[i].match, gap);
      check($sformatf("vec%0d_gap", i), 32'(gap), 32'(vecs[i].gap));
      check($sformatf("vec%0d_cur", i), {30'd0, cur_player}, 32'(vecs[i].cur));
      check($sformatf("vec%0d_pos", i), {12'd0, pos_flat}, {12'd0, vecs[i].pos});
    end
    check("table_cur_pos", {27'd0, cur_pos}, 32'd5);

    // Player 2 at 5 walks over 6 and 7; reset lands mid-walk between edges.
    res_valid = 1'b1;
    res_match = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    res_match = 1'b0;
    check("midstep_state", {29'd0, state}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", {29'd0, state}, 32'd0);
    check("arst_ready", {31'd0, res_ready}, 32'd0);
    check("arst_pos", {12'd0, pos_flat}, 32'd0);
    check("arst_cur", {30'd0, cur_player}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_arst_state", {29'd0, state}, 32'd0);

    // n=2 game: player 1 laps the track and wins.
    do_start(3'd2);
    check("g2_load", {29'd0, state}, 32'd1);
    @(negedge clk);
    check("g2_wait", {29'd0, state}, 32'd2);
    send_result(1'b0, gap);
    check("g2_miss_gap", 32'(gap), 32'd2);
    check("g2_miss_cur", {30'd0, cur_player}, 32'd1);
    do_start(3'd3);
    check("start_in_wait_state", {29'd0, state}, 32'd2);
    check("start_in_wait_cur", {30'd0, cur_player}, 32'd1);
    for (int k = 1; k <= 23; k++) begin
      send_result(1'b1, gap);
      check($sformatf("lap%0d_gap", k), 32'(gap), 32'd3);
      check($sformatf("lap%0d_pos", k), {12'd0, pos_flat}, {12'd0, pk(0, k, 0, 0)});
    end
    res_valid = 1'b1;
    res_match = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    res_match = 1'b0;
    check("winstep_state", {29'd0, state}, 32'd3);
    @(negedge clk);
    check("wincheck_state", {29'd0, state}, 32'd4);
    @(negedge clk);
    check("done_state", {29'd0, state}, 32'd6);
    check("done_win", {31'd0, win}, 32'd1);
    check("done_winner", {30'd0, winner}, 32'd1);
    check("done_pos", {12'd0, pos_flat}, 32'd0);
    check("done_ready", {31'd0, res_ready}, 32'd0);

    res_valid = 1'b1;
    res_match = 1'b1;
    repeat (4) @(negedge clk);
    res_valid = 1'b0;
    res_match = 1'b0;
    check("done_ign_state", {29'd0, state}, 32'd6);
    check("done_ign_pos", {12'd0, pos_flat}, 32'd0);
    check("done_ign_win", {31'd0, win}, 32'd1);
    check("done_ign_winner", {30'd0, winner}, 32'd1);

    do_start(3'd5);
    check("done_bad_cfg_err", {31'd0, cfg_err}, 32'd1);
    check("done_bad_state", {29'd0, state}, 32'd6);
    check("done_bad_win", {31'd0, win}, 32'd1);
    do_start(3'd2);
    check("restart_state", {29'd0, state}, 32'd1);
    check("restart_win", {31'd0, win}, 32'd0);
    @(negedge clk);
    check("restart_wait", {29'd0, state}, 32'd2);
    check("restart_cur", {30'd0, cur_player}, 32'd0);
    check("restart_pos", {12'd0, pos_flat}, 32'd0);
    check("restart_ready", {31'd0, res_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
